// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency-sweep controller.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam int unsigned DWELL_MIN = 1;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter timing how long each sweep step is held.
module dwell_timer
  import sweep_pkg::*;
#(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               hold,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expired
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer driving the phase-accumulator step_size/en.
// SWEEP_PINGPONG_EN: bounce between start and stop endlessly; done tied 0.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [WIDTH-1:0]   cfg_start_step,
  input  logic [WIDTH-1:0]   cfg_stop_step,
  input  logic [WIDTH-1:0]   cfg_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [WIDTH-1:0]   step_size,
  output logic               cnt_en,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  logic [WIDTH-1:0]   step_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   inc_q, inc_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic               tmr_load, tmr_hold, expired, finished;
  logic [DWELL_W-1:0] tmr_val;
`ifdef SWEEP_PINGPONG_EN
  logic [WIDTH-1:0]   oth_q, oth_d;
`endif

  function automatic logic [DWELL_W-1:0] reload_of(input logic [DWELL_W-1:0] d);
    reload_of = (d < DWELL_W'(DWELL_MIN)) ? '0 : d - DWELL_W'(DWELL_MIN);
  endfunction

  // One extra bit so the clamp sees overflow/underflow instead of a wrapped value.
  function automatic logic [WIDTH-1:0] next_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] inc,
                                                 input logic [WIDTH-1:0] tgt,
                                                 input dir_e             dir);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    sum  = {1'b0, cur} + {1'b0, inc};
    diff = {1'b0, cur} - {1'b0, inc};
    if (dir == DIR_UP) next_step = (sum >= {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
    else               next_step = (diff[WIDTH] || diff <= {1'b0, tgt}) ? tgt : diff[WIDTH-1:0];
  endfunction

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .hold     (tmr_hold),
    .load_val (tmr_val),
    .expired  (expired)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    step_d   = step_size;
    tgt_d    = tgt_q;
    inc_d    = inc_q;
    reload_d = reload_q;
    tmr_load = 1'b0;
    tmr_hold = 1'b1;
    tmr_val  = reload_q;
    finished = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    oth_d    = oth_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          step_d   = cfg_start_step;
          tgt_d    = cfg_stop_step;
          inc_d    = cfg_inc;
          reload_d = reload_of(cfg_dwell);
          dir_d    = (cfg_stop_step >= cfg_start_step) ? DIR_UP : DIR_DOWN;
          tmr_load = 1'b1;
          tmr_val  = reload_of(cfg_dwell);
`ifdef SWEEP_PINGPONG_EN
          oth_d    = cfg_start_step;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // The cycle that samples pause still counts toward the dwell,
          // so every step gets exactly max(dwell,1) enabled cycles.
          tmr_hold = 1'b0;
          if (expired) begin
`ifdef SWEEP_PINGPONG_EN
            tmr_load = 1'b1;
            if (step_size == tgt_q) begin
              dir_d  = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
              tgt_d  = oth_q;
              oth_d  = tgt_q;
              step_d = next_step(step_size, inc_q, oth_q, dir_d);
            end else begin
              step_d = next_step(step_size, inc_q, tgt_q, dir_q);
            end
`else
            if (step_size == tgt_q || inc_q == '0) begin
              finished = 1'b1;
            end else begin
              tmr_load = 1'b1;
              step_d   = next_step(step_size, inc_q, tgt_q, dir_q);
            end
`endif
          end
          state_d = finished ? DONE : (pause ? PAUSE : RUN);
        end
      end
      PAUSE: begin
        if (abort)       state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      step_size <= '0;
      tgt_q     <= '0;
      inc_q     <= '0;
      reload_q  <= '0;
      cnt_en    <= 1'b0;
      busy      <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      oth_q     <= '0;
`else
      done      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      step_size <= step_d;
      tgt_q     <= tgt_d;
      inc_q     <= inc_d;
      reload_q  <= reload_d;
      cnt_en    <= (state_d == RUN);
      busy      <= (state_d == RUN) || (state_d == PAUSE);
`ifdef SWEEP_PINGPONG_EN
      oth_q     <= oth_d;
`else
      done      <= (state_d == DONE);
`endif
    end
  end

`ifdef SWEEP_PINGPONG_EN
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized self-checking bench for sweep_ctrl against a step-list reference model.
module tb_sweep_ctrl;

  typedef int iq_t[$];
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, pause;
  logic [7:0]  cfg_start_step, cfg_stop_step, cfg_inc;
  logic [15:0] cfg_dwell;
  logic [7:0]  step_size;
  logic        cnt_en, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: list of step values, each held for d enabled cycles
  mode_t mode;
  iq_t   steps;
  int    d, p, mstep, mlast;
  iq_t   trace;
  int    en10;

  always #5 clk = ~clk;

  sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .pause          (pause),
    .cfg_start_step (cfg_start_step),
    .cfg_stop_step  (cfg_stop_step),
    .cfg_inc        (cfg_inc),
    .cfg_dwell      (cfg_dwell),
    .step_size      (step_size),
    .cnt_en         (cnt_en),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic iq_t walk(input int a, input int b, input int inc);
    iq_t q;
    int  v;
    v = a;
    q.push_back(v);
    while (v != b && inc != 0) begin
      if (b >= a) v = (v + inc > b) ? b : v + inc;
      else        v = (v - inc < b) ? b : v - inc;
      q.push_back(v);
    end
    return q;
  endfunction

  task automatic build(input int s, input int e, input int inc, input int dw);
    iq_t f;
`ifdef SWEEP_PINGPONG_EN
    iq_t b;
`endif
    d = (dw == 0) ? 1 : dw;
    f = walk(s, e, inc);
    steps = f;
`ifdef SWEEP_PINGPONG_EN
    if (f.size() == 1) begin
      while (steps.size() < 4000) steps.push_back(s);
    end else begin
      b = walk(e, s, inc);
      while (steps.size() < 4000) begin
        for (int i = 1; i < b.size(); i++) steps.push_back(b[i]);
        for (int i = 1; i < f.size(); i++) steps.push_back(f[i]);
      end
    end
    mlast = 32'h7fff_ffff;
`else
    mlast = steps.size() * d;
`endif
  endtask

  task automatic model_step();
    case (mode)
      M_IDLE: if (start && !abort) begin
        build(int'(cfg_start_step), int'(cfg_stop_step), int'(cfg_inc), int'(cfg_dwell));
        p     = 0;
        mstep = steps[0];
        mode  = M_RUN;
      end
      M_RUN: if (abort) mode = M_IDLE;
      else begin
        p++;
        if (p >= mlast) mode = M_DONE;
        else begin
          mstep = steps[p / d];
          mode  = pause ? M_PAUSE : M_RUN;
        end
      end
      M_PAUSE: if (abort) mode = M_IDLE; else if (!pause) mode = M_RUN;
      M_DONE:  mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("step_size", 32'(step_size), 32'(mstep));
    check("cnt_en", 32'(cnt_en), 32'(mode == M_RUN));
    check("busy", 32'(busy), 32'(mode == M_RUN || mode == M_PAUSE));
    check("done", 32'(done), 32'(mode == M_DONE));
    if (cnt_en && (trace.size() == 0 || trace[$] != int'(step_size))) trace.push_back(int'(step_size));
    if (cnt_en && step_size == 8'd10) en10++;
  endtask

  task automatic kick(input int s, input int e, input int inc, input int dw);
    trace.delete();
    en10 = 0;
    cfg_start_step = 8'(s);
    cfg_stop_step  = 8'(e);
    cfg_inc        = 8'(inc);
    cfg_dwell      = 16'(dw);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cfg_start_step = 8'($urandom);
    cfg_stop_step  = 8'($urandom);
    cfg_inc        = 8'($urandom);
    cfg_dwell      = 16'($urandom_range(0, 6));
  endtask

  task automatic run_until_idle(input int cap);
    int n;
    n = 0;
    while (mode != M_IDLE && n < cap) begin
      cycle();
      n++;
    end
    check("timeout", 32'(mode == M_IDLE), 32'd1);
  endtask

  task automatic check_trace(input string tag, input iq_t exp);
    check({tag, "_len"}, 32'(trace.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      check(tag, 32'(trace[i]), 32'(exp[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    iq_t exp;
    int  cap;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    cfg_start_step = '0; cfg_stop_step = '0; cfg_inc = '0; cfg_dwell = '0;
    mode = M_IDLE; mstep = 0; d = 1; p = 0; mlast = 0; en10 = 0;
    repeat (2) @(negedge clk);
    check("rst_step", 32'(step_size), 32'd0);
    check("rst_en", 32'(cnt_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (2) cycle();

`ifndef SWEEP_PINGPONG_EN
    kick(10, 40, 10, 3);
    run_until_idle(100);
    exp = '{10, 20, 30, 40};
    check_trace("t1_trace", exp);

    kick(200, 50, 60, 1);
    run_until_idle(100);
    exp = '{200, 140, 80, 50};
    check_trace("t2_trace", exp);

    kick(250, 255, 10, 2);
    run_until_idle(100);
    exp = '{250, 255};
    check_trace("t3_trace", exp);

    kick(10, 20, 10, 5);
    cycle();
    pause = 1'b1;
    repeat (2) cycle();
    check("t4_paused_en", 32'(cnt_en), 32'd0);
    pause = 1'b0;
    run_until_idle(100);
    check("t4_en_at_10", 32'(en10), 32'd5);

    kick(10, 40, 10, 3);
    repeat (3) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t5_abort_en", 32'(cnt_en), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    repeat (3) cycle();

    cfg_start_step = 8'd5; cfg_stop_step = 8'd9; cfg_inc = 8'd1; cfg_dwell = 16'd1;
    start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);
`else
    kick(0, 20, 10, 1);
    repeat (11) cycle();
    exp = '{0, 10, 20, 10, 0, 10, 20, 10, 0, 10, 20, 10};
    check_trace("t6_trace", exp);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
`endif

    kick(30, 100, 7, 2);
    repeat (5) cycle();
    #2;
    rst = 1'b0;
    #1;
    check("arst_step", 32'(step_size), 32'd0);
    check("arst_en", 32'(cnt_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    mode = M_IDLE;
    mstep = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle();

    for (int it = 0; it < 40; it++) begin
      kick($urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255),
           $urandom_range(0, 4));
      cap = $urandom_range(20, 400);
      for (int n = 0; n < cap && mode != M_IDLE; n++) begin
        if ($urandom_range(0, 7) == 0) pause = ~pause;
        abort = ($urandom_range(0, 99) == 0);
        start = ($urandom_range(0, 15) == 0);
        cycle();
        start = 1'b0;
        abort = 1'b0;
      end
      pause = 1'b0;
      if (mode != M_IDLE) begin
        abort = 1'b1;
        cycle();
        abort = 1'b0;
      end
      check("rand_idle", 32'(busy), 32'd0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
